// File: rtl/lcd_nibble_driver_if.sv
// Bus port bundle for the LCD nibble driver peripheral.
// master drives select/write/address/data; slave returns read data.
interface lcd_nibble_driver_if;
  logic        chipSelect;
  logic        write;
  logic        regSel;
  logic [31:0] dataIn;
  logic [31:0] dataOut;

  modport master (
    output chipSelect, write, regSel, dataIn,
    input  dataOut
  );

  modport slave (
    input  chipSelect, write, regSel, dataIn,
    output dataOut
  );
endinterface

// File: rtl/lcd_nibble_driver.sv
// HD44780-style 4-bit LCD driver: bus-fed command FIFO feeding a nibble FSM.
// Ports: clk, reset (sync, active-low), bus (slave), lcd = {E, RS, D7..D4}.
module lcd_nibble_driver #(
  parameter int T_SETUP    = 2,
  parameter int T_EN       = 12,
  parameter int T_HOLD     = 12,
  parameter int T_EXEC     = 600,
  parameter int T_CLEAR    = 20000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  lcd_nibble_driver_if.slave  bus,
  output logic [5:0]          lcd
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TW   = (T_CLEAR > T_EXEC) ? T_CLEAR : T_EXEC;
  localparam int TS   = (T_EN > T_HOLD) ? T_EN : T_HOLD;
  localparam int TMAX = (TW > TS) ? TW : TS;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EN_HI = 3'd2;
  localparam logic [2:0] S_EN_LO = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [3:0]    r_count;
  logic          r_ovf;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rs;
  logic [7:0]    r_byte;
  logic          r_hi;
  logic [5:0]    r_lcd;

  logic          w_push;
  logic          w_ctrl;
  logic          w_flush;
  logic          w_ovf_clr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_accept;
  logic          w_busy;
  logic          w_done;
  logic          w_clr_cmd;
  logic [3:0]    w_nib;
  logic [CW-1:0] w_wait_ld;
  logic [5:0]    w_lcd_nx;
  logic          w_unused;

  assign w_push    = bus.chipSelect & bus.write & ~bus.regSel;
  assign w_ctrl    = bus.chipSelect & bus.write & bus.regSel;
  assign w_flush   = w_ctrl & bus.dataIn[0];
  assign w_ovf_clr = w_ctrl & bus.dataIn[1];
  assign w_empty   = (r_count == 4'd0);
  assign w_full    = (r_count == 4'(FIFO_DEPTH));
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  // a full FIFO still takes a push when the head leaves on the same edge
  assign w_accept  = w_push & (~w_full | w_pop);
  assign w_busy    = (r_state != S_IDLE);
  assign w_done    = (r_cnt == '0);
  assign w_nib     = r_hi ? r_byte[7:4] : r_byte[3:0];
  assign w_clr_cmd = ~r_rs & ((r_byte == 8'h01) | (r_byte == 8'h02));
  assign w_wait_ld = w_clr_cmd ? CW'(T_CLEAR) : CW'(T_EXEC);
  assign w_unused  = ^bus.dataIn[31:9];

  assign bus.dataOut = bus.regSel ? 32'b0 :
    {25'b0, r_count[2:0], r_ovf, w_empty, w_full, w_busy};

  assign lcd = r_lcd;

  always_ff @(posedge clk) begin
    if (reset && w_accept) begin
      r_mem[r_wp] <= bus.dataIn[8:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_count <= 4'd0;
      end else begin
        if (w_accept) r_wp <= r_wp + AW'(1);
        if (w_pop)    r_rp <= r_rp + AW'(1);
        unique case ({w_accept, w_pop})
          2'b10:   r_count <= r_count + 4'd1;
          2'b01:   r_count <= r_count - 4'd1;
          default: r_count <= r_count;
        endcase
      end
      if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end else if (w_push && !w_accept) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // pins are registered from the state, so they trail it by one cycle;
  // WAIT holds one extra state cycle so E stays low a full wait time
  always_comb begin
    w_lcd_nx = 6'b0;
    unique case (r_state)
      S_SETUP, S_EN_LO: w_lcd_nx = {1'b0, r_rs, w_nib};
      S_EN_HI:          w_lcd_nx = {1'b1, r_rs, w_nib};
      default:          w_lcd_nx = 6'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_byte  <= 8'h00;
      r_hi    <= 1'b0;
      r_lcd   <= 6'b0;
    end else begin
      r_lcd <= w_lcd_nx;
      if (!w_done) r_cnt <= r_cnt - CW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_rs, r_byte} <= r_mem[r_rp];
            r_hi    <= 1'b1;
            r_cnt   <= CW'(T_SETUP - 1);
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_done) begin
            r_cnt   <= CW'(T_EN - 1);
            r_state <= S_EN_HI;
          end
        end
        S_EN_HI: begin
          if (w_done) begin
            r_cnt   <= CW'(T_HOLD - 1);
            r_state <= S_EN_LO;
          end
        end
        S_EN_LO: begin
          if (w_done) begin
            if (r_hi) begin
              r_hi    <= 1'b0;
              r_cnt   <= CW'(T_SETUP - 1);
              r_state <= S_SETUP;
            end else begin
              r_cnt   <= w_wait_ld;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Directed self-checking bench for lcd_nibble_driver.
// Checks pin timing, FIFO status, overflow, flush and reset behaviour.
module tb_lcd_nibble_driver;

  logic       clk;
  logic       reset;
  logic [5:0] lcd;
  int         errors;
  int         checks;

  lcd_nibble_driver_if bus();

  lcd_nibble_driver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .lcd   (lcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic sel, input logic [31:0] d);
    bus.chipSelect = 1'b1;
    bus.write      = 1'b1;
    bus.regSel     = sel;
    bus.dataIn     = d;
    @(posedge clk);
    #1;
    bus.chipSelect = 1'b0;
    bus.write      = 1'b0;
    bus.regSel     = 1'b0;
    bus.dataIn     = 32'h0;
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int c;
    c = 0;
    while (bus.dataOut[0] !== 1'b0 && c < maxc) begin
      tick();
      c++;
    end
    checks++;
    if (c >= maxc) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0",
               bus.dataOut[0], c);
    end
  endtask

  // pin pattern n cycles after the pop edge of one byte
  function automatic logic [5:0] exp_lcd(int n, logic rs, logic [7:0] b);
    int m;
    int p;
    logic [3:0] nib;
    if (n < 1 || n > 52) return 6'b0;
    m   = n - 1;
    nib = (m < 26) ? b[7:4] : b[3:0];
    p   = m % 26;
    return {(p >= 2 && p < 14), rs, nib};
  endfunction

  task automatic test_reset();
    bus.chipSelect = 1'b1;
    bus.write      = 1'b1;
    bus.regSel     = 1'b0;
    bus.dataIn     = 32'h141;
    repeat (3) tick();
    bus.chipSelect = 1'b0;
    bus.write      = 1'b0;
    bus.dataIn     = 32'h0;
    #1;
    checks++;
    if (lcd !== 6'b0) begin
      errors++;
      $display("FAIL reset_lcd: got %b, required 000000", lcd);
    end
    checks++;
    if (bus.dataOut !== 32'h4) begin
      errors++;
      $display("FAIL reset_status: got %h, required 00000004", bus.dataOut);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.dataOut !== 32'h4) begin
      errors++;
      $display("FAIL reset_ignored_push: got %h, required 00000004",
               bus.dataOut);
    end
    bus.regSel = 1'b1;
    #1;
    checks++;
    if (bus.dataOut !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_read: got %h, required 00000000", bus.dataOut);
    end
    bus.regSel = 1'b0;
    #1;
  endtask

  task automatic test_char();
    logic [5:0] e;
    logic       eb;
    bus_write(1'b0, 32'h141);
    checks++;
    if (bus.dataOut !== 32'h10) begin
      errors++;
      $display("FAIL char_queued: got %h, required 00000010", bus.dataOut);
    end
    tick();
    checks++;
    if (bus.dataOut !== 32'h5) begin
      errors++;
      $display("FAIL char_popped: got %h, required 00000005", bus.dataOut);
    end
    for (int n = 0; n <= 653; n++) begin
      e  = exp_lcd(n, 1'b1, 8'h41);
      eb = (n < 653);
      checks++;
      if (lcd !== e) begin
        errors++;
        $display("FAIL char_lcd n=%0d: got %b, required %b", n, lcd, e);
      end
      checks++;
      if (bus.dataOut[0] !== eb) begin
        errors++;
        $display("FAIL char_busy n=%0d: got %b, required %b",
                 n, bus.dataOut[0], eb);
      end
      if (n < 653) tick();
    end
  endtask

  task automatic test_clear();
    bus_write(1'b0, 32'h001);
    tick();
    for (int n = 1; n <= 20053; n++) begin
      tick();
      if (n == 52) begin
        checks++;
        if (lcd !== 6'b000001) begin
          errors++;
          $display("FAIL clear_last_nib: got %b, required 000001", lcd);
        end
      end
      if (n == 10000) begin
        checks++;
        if (lcd !== 6'b0) begin
          errors++;
          $display("FAIL clear_wait_lcd: got %b, required 000000", lcd);
        end
      end
      if (n == 20052) begin
        checks++;
        if (bus.dataOut[0] !== 1'b1) begin
          errors++;
          $display("FAIL clear_busy_20052: got %b, required 1",
                   bus.dataOut[0]);
        end
      end
      if (n == 20053) begin
        checks++;
        if (bus.dataOut[0] !== 1'b0) begin
          errors++;
          $display("FAIL clear_busy_20053: got %b, required 0",
                   bus.dataOut[0]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int nz;
    bus_write(1'b0, 32'h141);
    tick();
    for (int i = 0; i < 5; i++) bus_write(1'b0, 32'h142 + i);
    checks++;
    if (bus.dataOut !== 32'h4B) begin
      errors++;
      $display("FAIL ovf_status: got %h, required 0000004b", bus.dataOut);
    end
    bus_write(1'b1, 32'h2);
    checks++;
    if (bus.dataOut !== 32'h43) begin
      errors++;
      $display("FAIL ovf_clear: got %h, required 00000043", bus.dataOut);
    end
    bus_write(1'b1, 32'h1);
    checks++;
    if (bus.dataOut !== 32'h5) begin
      errors++;
      $display("FAIL ovf_flush: got %h, required 00000005", bus.dataOut);
    end
    wait_idle(800);
    nz = 0;
    repeat (700) begin
      tick();
      if (lcd !== 6'b0 || bus.dataOut[0] !== 1'b0) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL ovf_after_flush: active cycles=%0d, required 0", nz);
    end
  endtask

  task automatic test_flush();
    int nz;
    bus_write(1'b0, 32'h1C3);
    bus_write(1'b0, 32'h1D4);
    bus_write(1'b0, 32'h1E5);
    bus_write(1'b1, 32'h1);
    checks++;
    if (bus.dataOut !== 32'h5) begin
      errors++;
      $display("FAIL flush_status: got %h, required 00000005", bus.dataOut);
    end
    for (int n = 3; n <= 653; n++) begin
      tick();
      if (n == 27) begin
        checks++;
        if (lcd !== 6'b010011) begin
          errors++;
          $display("FAIL flush_inflight: got %b, required 010011", lcd);
        end
      end
      if (n == 652) begin
        checks++;
        if (bus.dataOut[0] !== 1'b1) begin
          errors++;
          $display("FAIL flush_busy_652: got %b, required 1",
                   bus.dataOut[0]);
        end
      end
      if (n == 653) begin
        checks++;
        if (bus.dataOut !== 32'h4) begin
          errors++;
          $display("FAIL flush_done: got %h, required 00000004",
                   bus.dataOut);
        end
      end
    end
    nz = 0;
    repeat (700) begin
      tick();
      if (lcd !== 6'b0) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL flush_dropped: active cycles=%0d, required 0", nz);
    end
  endtask

  task automatic test_reset_mid();
    int ep;
    bus_write(1'b0, 32'h141);
    bus_write(1'b0, 32'h142);
    repeat (4) tick();
    checks++;
    if (lcd !== 6'b110100) begin
      errors++;
      $display("FAIL mid_en_hi: got %b, required 110100", lcd);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (lcd !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_lcd: got %b, required 000000", lcd);
    end
    checks++;
    if (bus.dataOut !== 32'h4) begin
      errors++;
      $display("FAIL mid_reset_status: got %h, required 00000004",
               bus.dataOut);
    end
    reset = 1'b1;
    ep = 0;
    repeat (700) begin
      tick();
      if (lcd[5] !== 1'b0 || bus.dataOut[0] !== 1'b0) ep++;
    end
    checks++;
    if (ep != 0) begin
      errors++;
      $display("FAIL mid_no_pulses: active cycles=%0d, required 0", ep);
    end
  endtask

  task automatic test_full_idle();
    logic [8:0] seq [5];
    logic [5:0] e;
    seq[0] = 9'h112;
    seq[1] = 9'h134;
    seq[2] = 9'h156;
    seq[3] = 9'h178;
    seq[4] = 9'h19A;
    bus_write(1'b0, 32'h141);
    tick();
    for (int i = 0; i < 4; i++) bus_write(1'b0, {23'b0, seq[i]});
    wait_idle(800);
    bus_write(1'b0, {23'b0, seq[4]});
    checks++;
    if (bus.dataOut !== 32'h43) begin
      errors++;
      $display("FAIL full_idle_push: got %h, required 00000043",
               bus.dataOut);
    end
    for (int b = 0; b < 5; b++) begin
      for (int n = 1; n <= 654; n++) begin
        tick();
        if (n == 1 || n == 27) begin
          e = exp_lcd(n, seq[b][8], seq[b][7:0]);
          checks++;
          if (lcd !== e) begin
            errors++;
            $display("FAIL order b=%0d n=%0d: got %b, required %b",
                     b, n, lcd, e);
          end
        end
        if (n == 653) begin
          checks++;
          if (bus.dataOut[0] !== 1'b0) begin
            errors++;
            $display("FAIL order_idle b=%0d: busy=%b, required 0",
                     b, bus.dataOut[0]);
          end
        end
      end
    end
    checks++;
    if (bus.dataOut !== 32'h4) begin
      errors++;
      $display("FAIL full_idle_drained: got %h, required 00000004",
               bus.dataOut);
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b0;
    bus.chipSelect = 1'b0;
    bus.write      = 1'b0;
    bus.regSel     = 1'b0;
    bus.dataIn     = 32'h0;
    test_reset();
    test_char();
    test_clear();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_full_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
